alu_seq_datapath: RTL and testbench

ALU_SEQ_DATAPATH -- requirements
Module: alu_seq_datapath

---
 rtl/alu_seq_datapath_if.sv | 39 +++
 rtl/alu_seq_datapath.sv | 135 +++++++++++++
 tb/tb_alu_seq_datapath.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_datapath_if.sv
// Command, register-file access and result bundle for alu_seq_datapath.
// The master modport drives the requests; the slave modport is the datapath side.
interface alu_seq_datapath_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
);
  localparam int AW = $clog2(NREGS);

  logic             i_wr_en;
  logic [AW-1:0]    i_wr_addr;
  logic [WIDTH-1:0] i_wr_data;
  logic             i_start;
  logic [AW-1:0]    i_rn;
  logic [AW-1:0]    i_rm;
  logic [AW-1:0]    i_rd;
  logic [1:0]       i_alu_op;
  logic [1:0]       i_shift;
  logic             i_asel;
  logic             i_bsel;
  logic [4:0]       i_imm;
  logic [AW-1:0]    i_dbg_addr;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_datapath_out;
  logic [2:0]       o_status;
  logic [WIDTH-1:0] o_dbg_data;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_start, i_rn, i_rm, i_rd,
           i_alu_op, i_shift, i_asel, i_bsel, i_imm, i_dbg_addr,
    input  o_busy, o_done, o_datapath_out, o_status, o_dbg_data
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_start, i_rn, i_rm, i_rd,
           i_alu_op, i_shift, i_asel, i_bsel, i_imm, i_dbg_addr,
    output o_busy, o_done, o_datapath_out, o_status, o_dbg_data
  );
endinterface

// File: rtl/alu_seq_datapath.sv
// Multi-cycle register-file ALU: load A, load B, execute, write back.
// Define STATUS_NV_EN to report overflow (V) and negative (N) in status; otherwise only Z.
module alu_seq_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  alu_seq_datapath_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, WB} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_rn, r_rm, r_rd;
  logic [1:0]       r_op, r_shift;
  logic             r_asel, r_bsel;
  logic [4:0]       r_imm;
  logic [WIDTH-1:0] r_a, r_b, r_c;
  logic [2:0]       r_status;
  logic             r_done;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] w_ain, w_bsh, w_bin, w_res;
  logic [2:0]       w_status;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.i_start) w_next = LOAD_A;
      LOAD_A:  w_next = LOAD_B;
      LOAD_B:  w_next = EXEC;
      EXEC:    w_next = WB;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Shifter acts on B only; the immediate bypasses it entirely.
  always_comb begin
    w_ain = r_asel ? '0 : r_a;
    w_bsh = r_b;
    case (r_shift)
      2'b01:   w_bsh = {r_b[WIDTH-2:0], 1'b0};
      2'b10:   w_bsh = {1'b0, r_b[WIDTH-1:1]};
      2'b11:   w_bsh = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
      default: w_bsh = r_b;
    endcase
    w_bin = r_bsel ? {{(WIDTH-5){1'b0}}, r_imm} : w_bsh;
    w_res = '0;
    case (r_op)
      2'b00:   w_res = w_ain + w_bin;
      2'b01:   w_res = w_ain - w_bin;
      2'b10:   w_res = w_ain & w_bin;
      default: w_res = ~w_bin;
    endcase
  end

`ifdef STATUS_NV_EN
  logic w_v;

  always_comb begin
    w_v = 1'b0;
    case (r_op)
      2'b00:   w_v = (w_ain[WIDTH-1] == w_bin[WIDTH-1]) && (w_res[WIDTH-1] != w_ain[WIDTH-1]);
      2'b01:   w_v = (w_ain[WIDTH-1] != w_bin[WIDTH-1]) && (w_res[WIDTH-1] != w_ain[WIDTH-1]);
      default: w_v = 1'b0;
    endcase
  end

  assign w_status = {w_v, w_res[WIDTH-1], (w_res == '0)};
`else
  assign w_status = {2'b00, (w_res == '0)};
`endif

  // External writes land at the start edge, so LOAD_A/LOAD_B already see them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rn     <= '0;
      r_rm     <= '0;
      r_rd     <= '0;
      r_op     <= '0;
      r_shift  <= '0;
      r_asel   <= 1'b0;
      r_bsel   <= 1'b0;
      r_imm    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= '0;
      r_done   <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_wr_en) r_regs[bus.i_wr_addr] <= bus.i_wr_data;
          if (bus.i_start) begin
            r_rn    <= bus.i_rn;
            r_rm    <= bus.i_rm;
            r_rd    <= bus.i_rd;
            r_op    <= bus.i_alu_op;
            r_shift <= bus.i_shift;
            r_asel  <= bus.i_asel;
            r_bsel  <= bus.i_bsel;
            r_imm   <= bus.i_imm;
          end
        end
        LOAD_A: r_a <= r_regs[r_rn];
        LOAD_B: r_b <= r_regs[r_rm];
        EXEC: begin
          r_c      <= w_res;
          r_status <= w_status;
        end
        WB: begin
          r_regs[r_rd] <= r_c;
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy         = (r_state != IDLE);
  assign bus.o_done         = r_done;
  assign bus.o_datapath_out = r_c;
  assign bus.o_status       = r_status;
  assign bus.o_dbg_data     = r_regs[bus.i_dbg_addr];
endmodule

// File: tb/tb_alu_seq_datapath.sv
// Testbench for alu_seq_datapath: directed operations with literal results plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_alu_seq_datapath;
  localparam int W = 16;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  alu_seq_datapath_if #(.WIDTH(W), .NREGS(N)) bus ();

  alu_seq_datapath #(.WIDTH(W), .NREGS(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   nTotal = 0;
  int   nBad = 0;
  logic checkEn = 1'b0;

  logic [W-1:0] mRegs [N];
  logic [W-1:0] mC, pRes;
  logic [2:0]   mStat, pStat;
  logic [2:0]   pRd;
  int           mCnt;
  logic         mDone;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Result of one operation straight from the arithmetic rules, as {status, result}.
  function automatic logic [18:0] modelAlu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] op, input logic [1:0] sh,
                                           input logic asel, input logic bsel, input logic [4:0] imm);
    logic [15:0] ain, bin, res;
    int sa, sb, full;
    logic v;
    ain = asel ? 16'd0 : a;
    sb = int'($signed(b));
    case (sh)
      2'd1:    bin = 16'(int'(b) * 2);
      2'd2:    bin = 16'(int'(b) / 2);
      2'd3:    bin = 16'((sb >= 0) ? sb / 2 : -((1 - sb) / 2));
      default: bin = b;
    endcase
    if (bsel) bin = {11'd0, imm};
    sa = int'($signed(ain));
    sb = int'($signed(bin));
    full = 0;
    v = 1'b0;
    case (op)
      2'd0: begin full = sa + sb; res = 16'(full); v = (full > 32767) || (full < -32768); end
      2'd1: begin full = sa - sb; res = 16'(full); v = (full > 32767) || (full < -32768); end
      2'd2: res = ain & bin;
      default: res = ~bin;
    endcase
`ifdef STATUS_NV_EN
    return {v, res[15], res == 16'd0, res};
`else
    return {2'b00, res == 16'd0, res};
`endif
  endfunction

  // Operation tracked as edges remaining; writes only accepted with nothing in flight.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) mRegs[i] = '0;
      mC = '0;
      mStat = '0;
      mCnt = 0;
      mDone = 1'b0;
    end else begin
      mDone = 1'b0;
      if (mCnt == 0) begin
        if (bus.i_wr_en) mRegs[bus.i_wr_addr] = bus.i_wr_data;
        if (bus.i_start) begin
          {pStat, pRes} = modelAlu(mRegs[bus.i_rn], mRegs[bus.i_rm], bus.i_alu_op, bus.i_shift,
                                   bus.i_asel, bus.i_bsel, bus.i_imm);
          pRd = bus.i_rd;
          mCnt = 4;
        end
      end else begin
        mCnt--;
        if (mCnt == 1) begin
          mC = pRes;
          mStat = pStat;
        end
        if (mCnt == 0) begin
          mRegs[pRd] = mC;
          mDone = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (checkEn) begin
      checkOutput("busy", 32'(bus.o_busy), 32'(mCnt != 0));
      checkOutput("done", 32'(bus.o_done), 32'(mDone));
      checkOutput("out", 32'(bus.o_datapath_out), 32'(mC));
      checkOutput("status", 32'(bus.o_status), 32'(mStat));
      checkOutput("dbg", 32'(bus.o_dbg_data), 32'(mRegs[bus.i_dbg_addr]));
    end
  end

  task automatic idleInputs();
    bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_start = 1'b0; bus.i_rn = '0; bus.i_rm = '0; bus.i_rd = '0;
    bus.i_alu_op = '0; bus.i_shift = '0; bus.i_asel = 1'b0; bus.i_bsel = 1'b0;
    bus.i_imm = '0; bus.i_dbg_addr = '0;
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [15:0] d);
    bus.i_wr_en = 1'b1; bus.i_wr_addr = a; bus.i_wr_data = d;
    @(negedge clk);
    bus.i_wr_en = 1'b0;
  endtask

  task automatic setCmd(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                        input logic [1:0] op, input logic [1:0] sh, input logic asel,
                        input logic bsel, input logic [4:0] imm);
    bus.i_rn = rn; bus.i_rm = rm; bus.i_rd = rd; bus.i_alu_op = op; bus.i_shift = sh;
    bus.i_asel = asel; bus.i_bsel = bsel; bus.i_imm = imm; bus.i_start = 1'b1;
  endtask

  // Issue at the current negedge and return at the negedge where done is seen.
  task automatic doOp(input string name, input logic [2:0] rn, input logic [2:0] rm,
                      input logic [2:0] rd, input logic [1:0] op, input logic [1:0] sh,
                      input logic asel, input logic bsel, input logic [4:0] imm,
                      input logic doWr, input logic [2:0] wa, input logic [15:0] wd);
    int lat;
    lat = 0;
    setCmd(rn, rm, rd, op, sh, asel, bsel, imm);
    bus.i_wr_en = doWr; bus.i_wr_addr = wa; bus.i_wr_data = wd;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      bus.i_wr_en = 1'b0;
      if (bus.o_done) begin
        lat = k;
        break;
      end
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'd5);
  endtask

  task automatic checkReg(input string name, input logic [2:0] a, input logic [15:0] exp);
    bus.i_dbg_addr = a;
    #1;
    checkOutput(name, 32'(bus.o_dbg_data), 32'(exp));
  endtask

  task automatic checkResult(input string name, input logic [15:0] expC, input logic [2:0] expS);
    checkOutput({name, "_c"}, 32'(bus.o_datapath_out), 32'(expC));
    checkOutput({name, "_model_c"}, 32'(mC), 32'(expC));
    checkOutput({name, "_status"}, 32'(bus.o_status), 32'(expS));
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 149) != 0);
      bus.i_wr_en = ($urandom_range(0, 2) == 0);
      bus.i_wr_addr = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       bus.i_wr_data = 16'h7FFF;
        1:       bus.i_wr_data = 16'h8000;
        default: bus.i_wr_data = 16'($urandom);
      endcase
      bus.i_start = ($urandom_range(0, 3) == 0);
      bus.i_rn = 3'($urandom_range(0, 7));
      bus.i_rm = 3'($urandom_range(0, 7));
      bus.i_rd = 3'($urandom_range(0, 7));
      bus.i_alu_op = 2'($urandom_range(0, 3));
      bus.i_shift = 2'($urandom_range(0, 3));
      bus.i_asel = ($urandom_range(0, 4) == 0);
      bus.i_bsel = ($urandom_range(0, 3) == 0);
      bus.i_imm = 5'($urandom_range(0, 31));
      bus.i_dbg_addr = 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dones;
    `ifdef STATUS_NV_EN
    logic [2:0] ovfStatus = 3'b110;
    `else
    logic [2:0] ovfStatus = 3'b000;
    `endif
    idleInputs();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkEn = 1'b1;
    checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("rst_done", 32'(bus.o_done), 32'd0);
    checkOutput("rst_out", 32'(bus.o_datapath_out), 32'd0);
    checkOutput("rst_status", 32'(bus.o_status), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    writeReg(3'd2, 16'd202);
    writeReg(3'd4, 16'd51);
    doOp("sub_asr", 3'd2, 3'd4, 3'd3, 2'b01, 2'b11, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 16'd0);
    checkResult("sub_asr", 16'd177, 3'b000);
    checkReg("sub_asr_r3", 3'd3, 16'd177);

    writeReg(3'd1, 16'd2);
    writeReg(3'd0, 16'd7);
    doOp("add_lsl", 3'd1, 3'd0, 3'd6, 2'b00, 2'b01, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 16'd0);
    checkResult("add_lsl", 16'd16, 3'b000);
    checkReg("add_lsl_r6", 3'd6, 16'd16);

    writeReg(3'd5, 16'd6);
    writeReg(3'd7, 16'd3);
    doOp("and_lsr", 3'd5, 3'd7, 3'd4, 2'b10, 2'b10, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 16'd0);
    checkResult("and_lsr", 16'd0, 3'b001);

    writeReg(3'd1, 16'h7FFF);
    writeReg(3'd2, 16'd1);
    doOp("ovf", 3'd1, 3'd2, 3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 16'd0);
    checkResult("ovf", 16'h8000, ovfStatus);

    doOp("wr_start", 3'd1, 3'd1, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 3'd1, 16'd9);
    checkResult("wr_start", 16'd18, 3'b000);
    doOp("b2b_imm", 3'd1, 3'd1, 3'd2, 2'b00, 2'b00, 1'b1, 1'b1, 5'd5, 1'b0, 3'd0, 16'd0);
    checkResult("b2b_imm", 16'd5, 3'b000);
    checkReg("b2b_r2", 3'd2, 16'd5);

    dones = 0;
    setCmd(3'd0, 3'd0, 3'd7, 2'b00, 2'b00, 1'b1, 1'b1, 5'd7);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus.i_start = 1'b0;
      if (k == 2) begin bus.i_start = 1'b1; bus.i_alu_op = 2'b11; end
      if (k == 3) bus.i_start = 1'b0;
      if (bus.o_done) dones++;
    end
    checkOutput("busy_start_dones", 32'(dones), 32'd1);
    checkResult("busy_start", 16'd7, 3'b000);

    setCmd(3'd1, 3'd1, 3'd6, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("abort_busy", 32'(bus.o_busy), 32'd0);
    checkResult("abort", 16'd0, 3'b000);
    checkReg("abort_r6", 3'd6, 16'd0);
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.o_done) dones++;
    end
    checkOutput("abort_dones", 32'(dones), 32'd0);

    applyStimulus(800);
    reset_n = 1'b1;
    idleInputs();
    repeat (10) @(negedge clk);
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end
endmodule
